// File: rtl/waveform_plotter.sv
// Scrolling oscilloscope trace for a 160x120 framebuffer: one column per audio sample,
// erased then redrawn as a vertical span joining the previous sample's row to the new one.
module waveform_plotter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COLOUR_WIDTH = 12,
  parameter logic [COLOUR_WIDTH-1:0] TRACE_COLOUR = 12'h0F0,
  parameter logic [COLOUR_WIDTH-1:0] BG_COLOUR    = 12'h000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    frame_done
);

  // state   | meaning
  // INIT    | fill the whole screen with BG_COLOUR, row-major
  // IDLE    | waiting for a sample (sample_ready=1)
  // CLEAR   | erase column x_col, rows 0..119
  // DRAW    | paint rows y_lo..y_hi of column x_col
  // ADVANCE | commit prev_y, step x_col, flag frame wrap
  typedef enum logic [2:0] {INIT, IDLE, CLEAR, DRAW, ADVANCE} state_t;

  state_t state, state_nx;
  logic [7:0] x_col, x_col_nx, x_nx;
  logic [6:0] prev_y, prev_y_nx, y_new, y_new_nx, y_end, y_end_nx, y_nx;
  logic [6:0] y_lo, y_hi, y_clamped;
  logic [COLOUR_WIDTH-1:0] colour_nx;
  logic plot_nx, ready_nx, frame_done_nx;
  logic [6:0] s7;
  logic signed [8:0] y_calc;

  // Top 7 bits of the sample give -64..63; screen row is 60 - s7, clamped to the screen.
  always_comb begin
    s7 = sample_in[SAMPLE_WIDTH-1 -: 7];
    y_calc = 9'sd60 - $signed({{2{s7[6]}}, s7});
    if (y_calc < 9'sd0)
      y_clamped = 7'd0;
    else if (y_calc > 9'sd119)
      y_clamped = 7'd119;
    else
      y_clamped = y_calc[6:0];
  end

  // Column 0 has no left neighbour, so it is never joined to column 159.
  always_comb begin
    if (x_col == 8'd0) begin
      y_lo = y_new;
      y_hi = y_new;
    end else if (prev_y < y_new) begin
      y_lo = prev_y;
      y_hi = y_new;
    end else begin
      y_lo = y_new;
      y_hi = prev_y;
    end
  end

  always_comb begin
    state_nx      = state;
    x_nx          = x;
    y_nx          = y;
    colour_nx     = colour;
    plot_nx       = 1'b0;
    ready_nx      = 1'b0;
    frame_done_nx = 1'b0;
    x_col_nx      = x_col;
    prev_y_nx     = prev_y;
    y_new_nx      = y_new;
    y_end_nx      = y_end;
    case (state)
      INIT: begin
        if (plot && x == 8'd159 && y == 7'd119) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
        end else begin
          plot_nx   = 1'b1;
          colour_nx = BG_COLOUR;
          // plot=0 here only straight after reset: present (0,0) first.
          if (!plot) begin
            x_nx = 8'd0;
            y_nx = 7'd0;
          end else if (x == 8'd159) begin
            x_nx = 8'd0;
            y_nx = y + 7'd1;
          end else begin
            x_nx = x + 8'd1;
          end
        end
      end
      IDLE: begin
        ready_nx = 1'b1;
        if (sample_valid && sample_ready) begin
          ready_nx  = 1'b0;
          y_new_nx  = y_clamped;
          state_nx  = CLEAR;
          plot_nx   = 1'b1;
          x_nx      = x_col;
          y_nx      = 7'd0;
          colour_nx = BG_COLOUR;
        end
      end
      CLEAR: begin
        plot_nx = 1'b1;
        if (y == 7'd119) begin
          state_nx  = DRAW;
          colour_nx = TRACE_COLOUR;
          y_nx      = y_lo;
          y_end_nx  = y_hi;
        end else begin
          y_nx = y + 7'd1;
        end
      end
      DRAW: begin
        if (y == y_end) begin
          state_nx      = ADVANCE;
          frame_done_nx = (x_col == 8'd159);
        end else begin
          plot_nx = 1'b1;
          y_nx    = y + 7'd1;
        end
      end
      ADVANCE: begin
        prev_y_nx = y_new;
        x_col_nx  = (x_col == 8'd159) ? 8'd0 : x_col + 8'd1;
        state_nx  = IDLE;
        ready_nx  = 1'b1;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INIT;
      x            <= 8'd0;
      y            <= 7'd0;
      colour       <= BG_COLOUR;
      plot         <= 1'b0;
      sample_ready <= 1'b0;
      frame_done   <= 1'b0;
      x_col        <= 8'd0;
      prev_y       <= 7'd60;
      y_new        <= 7'd60;
      y_end        <= 7'd0;
    end else begin
      state        <= state_nx;
      x            <= x_nx;
      y            <= y_nx;
      colour       <= colour_nx;
      plot         <= plot_nx;
      sample_ready <= ready_nx;
      frame_done   <= frame_done_nx;
      x_col        <= x_col_nx;
      prev_y       <= prev_y_nx;
      y_new        <= y_new_nx;
      y_end        <= y_end_nx;
    end
  end

endmodule
